// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve immediately.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       div_op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] result_q;
   logic [CW-1:0]    cnt_q;
   logic             rem_op_q;
   logic             negq_q;
   logic             negr_q;
   logic             busy_q;
   logic             done_q;

   logic             sgn_op;
   logic             div0;
   logic             ovf;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;

   always_comb begin
      sgn_op = ~div_op[0];
      div0   = (b == '0);
      ovf    = sgn_op
               && (a == {1'b1, {(WIDTH-1){1'b0}}})
               && (b == '1);
      a_abs  = (sgn_op && a[WIDTH-1]) ? -a : a;
      b_abs  = (sgn_op && b[WIDTH-1]) ? -b : b;
   end

   // Partial remainder can reach 2*divisor-1, so the trial is one bit wider.
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic             qbit;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;
   logic [WIDTH-1:0] res_raw;
   logic             res_neg;
   logic [WIDTH-1:0] result_d;

   always_comb begin
      rem_sh   = {rem_q, quo_q[WIDTH-1]};
      trial    = rem_sh - {1'b0, dvs_q};
      qbit     = ~trial[WIDTH];
      rem_d    = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_d    = {quo_q[WIDTH-2:0], qbit};
      res_raw  = rem_op_q ? rem_d : quo_d;
      res_neg  = rem_op_q ? negr_q : negq_q;
      result_d = res_neg ? -res_raw : res_raw;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         rem_op_q <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start && !flush) begin
                  rem_op_q <= div_op[1];
                  busy_q   <= 1'b1;
                  if (div0) begin
                     result_q <= div_op[1] ? a : '1;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else if (ovf) begin
                     result_q <= div_op[1] ? '0 : a;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     quo_q   <= a_abs;
                     rem_q   <= '0;
                     dvs_q   <= b_abs;
                     cnt_q   <= CW'(WIDTH-1);
                     negq_q  <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                     negr_q  <= sgn_op & a[WIDTH-1];
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  quo_q <= quo_d;
                  rem_q <= rem_d;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == '0) begin
                     result_q <= result_d;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider.
// Inputs driven and outputs sampled on the falling edge.
module tb_seq_divider;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  div_op;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   seq_divider #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .flush  (flush),
      .a      (a),
      .b      (b),
      .div_op (div_op),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Waits for done after an accepting edge; scrambles operands meanwhile.
   task automatic wait_done(input logic [31:0] exp,
                            input int exp_lat,
                            input string tag,
                            input bit hold);
      int lat;
      int nbusy;
      lat   = 0;
      nbusy = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         a      = $urandom;
         b      = $urandom;
         div_op = 2'($urandom_range(0, 3));
         if (busy) nbusy++;
         if (done) lat = k;
      end
      start = 1'b0;
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_res"}, result, exp);
      check({tag, "_busy"}, 32'(nbusy), 32'(exp_lat));
   endtask

   task automatic run_op(input logic [31:0] ta,
                         input logic [31:0] tb_v,
                         input logic [1:0] op,
                         input logic [31:0] exp,
                         input int exp_lat,
                         input string tag,
                         input bit hold);
      @(negedge clk);
      a      = ta;
      b      = tb_v;
      div_op = op;
      start  = 1'b1;
      wait_done(exp, exp_lat, tag, hold);
   endtask

   initial begin
      bit seen;
      rst    = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      a      = '0;
      b      = '0;
      div_op = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res", result, 32'd0);

      run_op(32'd100, 32'd7, OP_DIVU, 32'd14, 33, "divu", 1'b0);
      run_op(32'd100, 32'd7, OP_REMU, 32'd2, 33, "remu", 1'b0);
      run_op(32'hFFFFFFF9, 32'd2, OP_DIV, 32'hFFFFFFFD, 33, "div_n7", 1'b0);
      run_op(32'hFFFFFFF9, 32'd2, OP_REM, 32'hFFFFFFFF, 33, "rem_n7", 1'b0);
      run_op(32'd7, 32'hFFFFFFFE, OP_REM, 32'd1, 33, "rem_7n2", 1'b0);
      run_op(32'd7, 32'hFFFFFFFE, OP_DIV, 32'hFFFFFFFD, 33, "div_7n2", 1'b0);
      run_op(32'h80000000, 32'd2, OP_DIV, 32'hC0000000, 33, "div_min2", 1'b0);
      run_op(32'hFFFFFFFF, 32'd1, OP_DIVU, 32'hFFFFFFFF, 33, "divu_max", 1'b0);

      run_op(32'h1234, 32'd0, OP_DIV, 32'hFFFFFFFF, 1, "div0", 1'b0);
      run_op(32'h1234, 32'd0, OP_DIVU, 32'hFFFFFFFF, 1, "divu0", 1'b0);
      run_op(32'h1234, 32'd0, OP_REM, 32'h1234, 1, "rem0", 1'b0);
      run_op(32'h1234, 32'd0, OP_REMU, 32'h1234, 1, "remu0", 1'b0);
      run_op(32'h80000000, 32'hFFFFFFFF, OP_DIV, 32'h80000000, 1, "ovf_div", 1'b0);
      run_op(32'h80000000, 32'hFFFFFFFF, OP_REM, 32'd0, 1, "ovf_rem", 1'b0);
      run_op(32'h80000000, 32'hFFFFFFFF, OP_DIVU, 32'd0, 33, "ovf_divu", 1'b0);

      run_op(32'hFFFFFFFF, 32'd16, OP_REMU, 32'hF, 33, "remu_16", 1'b0);

      // Flush in cycle T+10, restart in T+11.
      @(negedge clk);
      a      = 32'd1000;
      b      = 32'd3;
      div_op = OP_DIVU;
      start  = 1'b1;
      seen   = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) seen = 1'b1;
         if (k == 10) flush = 1'b1;
      end
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_nodone", 32'(seen), 32'd0);
      check("flush_res", result, 32'hF);
      a      = 32'd50;
      b      = 32'd5;
      div_op = OP_DIVU;
      start  = 1'b1;
      wait_done(32'd10, 33, "after_flush", 1'b0);

      // Start together with flush in IDLE is dropped.
      @(negedge clk);
      a      = 32'd9;
      b      = 32'd3;
      div_op = OP_DIVU;
      start  = 1'b1;
      flush  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("idle_flush_busy", 32'(busy), 32'd0);
      check("idle_flush_res", result, 32'd10);

      run_op(32'd12345, 32'd100, OP_DIVU, 32'd123, 33, "hold_start", 1'b1);

      // Reset mid-CALC.
      @(negedge clk);
      a      = 32'd999;
      b      = 32'd9;
      div_op = OP_DIVU;
      start  = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_res", result, 32'd0);

      run_op(32'd1000000, 32'd999, OP_DIVU, 32'd1001, 33, "b2b_0", 1'b0);
      run_op(32'd81, 32'd9, OP_DIVU, 32'd9, 33, "b2b_1", 1'b0);
      run_op(32'hDEADBEEF, 32'h10, OP_DIVU, 32'h0DEADBEE, 33, "b2b_2", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative 32-cycle radix-2 divider for RV32M DIV/DIVU/REM/REMU.
- Sits in the execute stage beside the combinational ALU and takes the same ID/EX operands.
- Its result is muxed with the ALU result into the EX/MEM register.
- While it is busy, hazard control holds the IF/ID and ID/EX stages.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- flush  input  1  abort the operation in progress (branch mispredict or trap).
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse: result valid.
- result  output  WIDTH  quotient or remainder; holds until the next accepted start or rst.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; busy=0, done=0, result=0; internal registers cleared. rst wins over start and flush.
- States: IDLE, CALC, DONE.
- IDLE -> start=1 at edge T: latch a, b, div_op.
  - Special cases go IDLE -> DONE, with done=1 in cycle T+1:
    - b==0: DIV/DIVU result=all ones; REM/REMU result=a.
    - signed op with a=0x80000000 and b=0xFFFFFFFF: DIV result=0x80000000; REM result=0.
  - Otherwise go to CALC.
  - Signed ops load |a| and |b|; the quotient sign is a[31]^b[31] and the remainder sign is a[31]; unsigned ops load a and b directly.
- CALC: restoring shift-subtract, one quotient bit per cycle, MSB first. The counter runs WIDTH-1 down to 0 with 33-bit trial subtraction. At count 0 the FSM goes to DONE. Total latency: start at edge T, done=1 in cycle T+WIDTH+1 (T+33).
- DONE: done=1 for exactly one cycle. result = sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU); negation is two's complement and applies only to signed ops with the sign flag set. Next state is IDLE.
- start in CALC/DONE is ignored; a new start is accepted in the cycle after DONE (IDLE).
- result updates only on the DONE-entry edge and is otherwise stable.
- flush=1 in CALC or DONE: next state IDLE, done=0 in the following cycle, result unchanged. flush with start in IDLE: start is dropped and nothing is accepted.
- start is not a level request: it is accepted once per IDLE visit. Upstream deasserts start on done, and stall logic uses busy | (start & ~done).
- Operand registers are internal. a, b and div_op may change after the accepting edge without effect.

Test Plan:
- DIVU a=100 b=7: done exactly 33 cycles after start, result=14. Repeat with REMU: result=2. busy high for cycles T+1..T+33.
- DIV a=-7 (0xFFFFFFF9) b=2: result=0xFFFFFFFD (-3). REM with same operands: 0xFFFFFFFF (-1). REM a=7 b=-2: 1.
- Divide by zero, a=0x1234: DIV and DIVU give 0xFFFFFFFF, REM and REMU give 0x1234, all with done at T+1. Overflow case 0x80000000 / 0xFFFFFFFF: DIV=0x80000000 and REM=0 at T+1; DIVU of the same operands takes 33 cycles and gives 0.
- flush asserted at T+10 of a DIVU: busy drops at T+11, no done pulse, result keeps its prior value. A new start at T+11 completes normally.
- start held high during CALC with different operands: ignored and result matches the first operands. rst pulsed mid-CALC: busy=0, done=0, result=0 the next cycle.
- Back-to-back DIVU ops (start re-asserted in the IDLE cycle after done): both results correct, and a always changes to a random value the cycle after acceptance without corrupting the result.
